// File: rtl/obstacle_scan_pkg.sv
// Shared definitions for the obstacle scan locator.
//
// Contents:
//   - default geometry and table sizes
//   - slot record type {absX, absY, row}
//   - scanner FSM state type
//   - idxWidth() helper for index widths (slot index, table index)
//
// Optional feature macro used by the top level: OBSTACLE_SCAN_DROP_COUNT_EN.
package obstacle_scan_pkg;

  localparam int SCREEN_WIDTH_DEF    = 10;
  localparam int PHY_WIDTH_DEF       = 14;
  localparam int OBSTACLE_WIDTH_DEF  = 10;
  localparam int OBSTACLE_HEIGHT_DEF = 20;
  localparam int MAX_OBSTACLES_DEF   = 16;
  localparam int LINE_SLOTS_DEF      = 4;

  // One obstacle that crosses the prepared line: world position plus the
  // row inside the sprite that this line shows.
  typedef struct packed {
    logic [PHY_WIDTH_DEF-1:0]    absX;
    logic [PHY_WIDTH_DEF-1:0]    absY;
    logic [SCREEN_WIDTH_DEF-1:0] row;
  } slot_rec_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // Index width for a table of n entries; never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obstacle_slot_match.sv
// Combinational pixel matcher for the active slot list.
//
// For every occupied slot it computes dx = pixel_x - slot_x (wrapping,
// SCREEN_WIDTH bits) and reports a match when dx < OBSTACLE_WIDTH. The
// lowest-numbered matching slot wins.
//
// Ports:
//   i_pixel_x     current screen column
//   i_slot_valid  per-slot occupancy
//   i_slot_x      per-slot left edge, low SCREEN_WIDTH bits of world x
//   o_hit         some slot matched
//   o_slot        index of the winning slot
//   o_dx          column within the winning obstacle
module obstacle_slot_match
  import obstacle_scan_pkg::*;
#(
  parameter int SCREEN_WIDTH   = SCREEN_WIDTH_DEF,
  parameter int LINE_SLOTS     = LINE_SLOTS_DEF,
  parameter int OBSTACLE_WIDTH = OBSTACLE_WIDTH_DEF,
  localparam int SLOT_W        = idxWidth(LINE_SLOTS)
) (
  input  logic [SCREEN_WIDTH-1:0]                 i_pixel_x,
  input  logic [LINE_SLOTS-1:0]                   i_slot_valid,
  input  logic [LINE_SLOTS-1:0][SCREEN_WIDTH-1:0] i_slot_x,
  output logic                                    o_hit,
  output logic [SLOT_W-1:0]                       o_slot,
  output logic [SCREEN_WIDTH-1:0]                 o_dx
);

  localparam logic [SCREEN_WIDTH-1:0] OBS_W = SCREEN_WIDTH'(OBSTACLE_WIDTH);

  logic [SCREEN_WIDTH-1:0] w_dx;

  // Walk from the highest slot down so the lowest matching slot is the
  // last one written and therefore wins.
  always_comb begin
    o_hit  = 1'b0;
    o_slot = '0;
    o_dx   = '0;
    w_dx   = '0;
    for (int s = LINE_SLOTS - 1; s >= 0; s--) begin
      w_dx = i_pixel_x - i_slot_x[s];
      if (i_slot_valid[s] && (w_dx < OBS_W)) begin
        o_hit  = 1'b1;
        o_slot = SLOT_W'(s);
        o_dx   = w_dx;
      end
    end
  end

endmodule

// File: rtl/obstacle_scan_locator.sv
// Obstacle scan locator: producer side of the obstacle pixel interface.
//
// Holds a writable table of obstacles in world coordinates. On every
// line_start it swaps the double-buffered slot list (shadow -> active) and
// scans the table, one entry per cycle, for obstacles crossing the next
// line. Each pixel is matched against the active slots and the result is
// registered one cycle later.
//
// Ports:
//   sys_clk, sys_rst            clock, asynchronous active-high reset
//   wr_valid/wr_ready           table write handshake (ready only in IDLE)
//   wr_idx, wr_entry_valid      entry index and enable (0 deletes)
//   wr_abs_x, wr_abs_y          obstacle world position (left/top edge)
//   camera_y, line_start,line_y line preparation request
//   pixel_valid, pixel_x        active-video pixel
//   obstacle_on, *_rom, *_abs_* registered pixel result
//   slot_overflow, scan_late    sticky error flags, cleared by flag_clr
//   drop_count                  dropped-hit counter (optional)
//
// Optional feature: define OBSTACLE_SCAN_DROP_COUNT_EN to add drop_count.
module obstacle_scan_locator
  import obstacle_scan_pkg::*;
#(
  parameter int SCREEN_WIDTH    = SCREEN_WIDTH_DEF,
  parameter int PHY_WIDTH       = PHY_WIDTH_DEF,
  parameter int OBSTACLE_WIDTH  = OBSTACLE_WIDTH_DEF,
  parameter int OBSTACLE_HEIGHT = OBSTACLE_HEIGHT_DEF,
  parameter int MAX_OBSTACLES   = MAX_OBSTACLES_DEF,
  parameter int LINE_SLOTS      = LINE_SLOTS_DEF,
  localparam int IDX_W          = idxWidth(MAX_OBSTACLES)
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic                    wr_entry_valid,
  input  logic [PHY_WIDTH-1:0]    wr_abs_x,
  input  logic [PHY_WIDTH-1:0]    wr_abs_y,
  input  logic [PHY_WIDTH-1:0]    camera_y,
  input  logic                    line_start,
  input  logic [SCREEN_WIDTH-1:0] line_y,
  input  logic                    pixel_valid,
  input  logic [SCREEN_WIDTH-1:0] pixel_x,
  output logic                    obstacle_on,
  output logic [SCREEN_WIDTH-1:0] obstacle_x_rom,
  output logic [SCREEN_WIDTH-1:0] obstacle_y_rom,
  output logic [PHY_WIDTH-1:0]    obstacle_abs_pos_x,
  output logic [PHY_WIDTH-1:0]    obstacle_abs_pos_y,
  output logic                    slot_overflow,
  output logic                    scan_late,
`ifdef OBSTACLE_SCAN_DROP_COUNT_EN
  output logic [7:0]              drop_count,
`endif
  input  logic                    flag_clr
);

  localparam int SLOT_W = idxWidth(LINE_SLOTS);
  localparam int CNT_W  = SLOT_W + 1;
  localparam logic [CNT_W-1:0]     SLOTS_FULL = CNT_W'(LINE_SLOTS);
  localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(MAX_OBSTACLES - 1);
  localparam logic [PHY_WIDTH-1:0] OBS_H      = PHY_WIDTH'(OBSTACLE_HEIGHT);

  scan_state_e             r_state;
  logic [IDX_W-1:0]        r_scanIdx;
  logic [PHY_WIDTH-1:0]    r_worldRow;

  logic [MAX_OBSTACLES-1:0] r_tabValid;
  logic [PHY_WIDTH-1:0]     r_tabX [MAX_OBSTACLES];
  logic [PHY_WIDTH-1:0]     r_tabY [MAX_OBSTACLES];

  slot_rec_t               r_shadow [LINE_SLOTS];
  slot_rec_t               r_active [LINE_SLOTS];
  logic [LINE_SLOTS-1:0]   r_shadowVld;
  logic [LINE_SLOTS-1:0]   r_activeVld;
  logic [CNT_W-1:0]        r_shadowCnt;

  logic                    r_slotOverflow;
  logic                    r_scanLate;

  logic                    w_wrAccept;
  logic [PHY_WIDTH-1:0]    w_diff;
  logic                    w_hit;
  logic                    w_full;
  logic                    w_drop;
  logic                    w_late;

  logic [LINE_SLOTS-1:0][SCREEN_WIDTH-1:0] w_slotX;
  logic                    w_matchHit;
  logic [SLOT_W-1:0]       w_matchSlot;
  logic [SCREEN_WIDTH-1:0] w_matchDx;

  // wr_ready also drops on a line_start cycle so a write can never race
  // the start of a scan.
  assign wr_ready   = (r_state == ST_IDLE) && !line_start;
  assign w_wrAccept = wr_valid && wr_ready;

  // A restarting line_start abandons the entry under test in that cycle.
  assign w_diff = r_worldRow - r_tabY[r_scanIdx];
  assign w_hit  = (r_state == ST_SCAN) && !line_start &&
                  r_tabValid[r_scanIdx] && (w_diff < OBS_H);
  assign w_full = (r_shadowCnt == SLOTS_FULL);
  assign w_drop = w_hit && w_full;
  assign w_late = line_start && (r_state == ST_SCAN);

  // Entry enables are reset so a fresh design starts with an empty table.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_tabValid <= '0;
    end else if (w_wrAccept) begin
      r_tabValid[wr_idx] <= wr_entry_valid;
    end
  end

  // Coordinates are only meaningful while the entry is enabled.
  always_ff @(posedge sys_clk) begin
    if (w_wrAccept) begin
      r_tabX[wr_idx] <= wr_abs_x;
      r_tabY[wr_idx] <= wr_abs_y;
    end
  end

  // Scanner FSM and the double-buffered slot lists. A line_start that
  // arrives mid-scan leaves the active list empty, since the shadow list
  // was only partly built.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      r_scanIdx   <= '0;
      r_worldRow  <= '0;
      r_shadowVld <= '0;
      r_activeVld <= '0;
      r_shadowCnt <= '0;
      for (int s = 0; s < LINE_SLOTS; s++) begin
        r_shadow[s] <= '0;
        r_active[s] <= '0;
      end
    end else if (line_start) begin
      r_state     <= ST_SCAN;
      r_scanIdx   <= '0;
      r_worldRow  <= camera_y + PHY_WIDTH'(line_y);
      r_shadowVld <= '0;
      r_shadowCnt <= '0;
      if (r_state == ST_IDLE) begin
        r_activeVld <= r_shadowVld;
        r_active    <= r_shadow;
      end else begin
        r_activeVld <= '0;
      end
    end else if (r_state == ST_SCAN) begin
      if (w_hit && !w_full) begin
        r_shadow[r_shadowCnt[SLOT_W-1:0]] <= '{absX: r_tabX[r_scanIdx],
                                               absY: r_tabY[r_scanIdx],
                                               row:  w_diff[SCREEN_WIDTH-1:0]};
        r_shadowVld[r_shadowCnt[SLOT_W-1:0]] <= 1'b1;
        r_shadowCnt <= r_shadowCnt + 1'b1;
      end
      if (r_scanIdx == LAST_IDX) begin
        r_state <= ST_IDLE;
      end else begin
        r_scanIdx <= r_scanIdx + 1'b1;
      end
    end
  end

  // Sticky flags: a new event in the same cycle as flag_clr keeps the flag set.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_slotOverflow <= 1'b0;
      r_scanLate     <= 1'b0;
    end else begin
      if (w_drop) begin
        r_slotOverflow <= 1'b1;
      end else if (flag_clr) begin
        r_slotOverflow <= 1'b0;
      end
      if (w_late) begin
        r_scanLate <= 1'b1;
      end else if (flag_clr) begin
        r_scanLate <= 1'b0;
      end
    end
  end

  assign slot_overflow = r_slotOverflow;
  assign scan_late     = r_scanLate;

`ifdef OBSTACLE_SCAN_DROP_COUNT_EN
  logic [7:0] r_dropCount;

  // Saturating count of hits lost to a full shadow list.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_dropCount <= 8'd0;
    end else if (flag_clr) begin
      r_dropCount <= {7'd0, w_drop};
    end else if (w_drop && (r_dropCount != 8'hFF)) begin
      r_dropCount <= r_dropCount + 8'd1;
    end
  end

  assign drop_count = r_dropCount;
`endif

  // The matcher only sees the low screen bits of each slot's world x.
  always_comb begin
    w_slotX = '0;
    for (int s = 0; s < LINE_SLOTS; s++) begin
      w_slotX[s] = r_active[s].absX[SCREEN_WIDTH-1:0];
    end
  end

  obstacle_slot_match #(
    .SCREEN_WIDTH   (SCREEN_WIDTH),
    .LINE_SLOTS     (LINE_SLOTS),
    .OBSTACLE_WIDTH (OBSTACLE_WIDTH)
  ) u_match (
    .i_pixel_x    (pixel_x),
    .i_slot_valid (r_activeVld),
    .i_slot_x     (w_slotX),
    .o_hit        (w_matchHit),
    .o_slot       (w_matchSlot),
    .o_dx         (w_matchDx)
  );

  // Registered pixel result; everything reads zero unless a valid pixel hit.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      obstacle_on        <= 1'b0;
      obstacle_x_rom     <= '0;
      obstacle_y_rom     <= '0;
      obstacle_abs_pos_x <= '0;
      obstacle_abs_pos_y <= '0;
    end else if (pixel_valid && w_matchHit) begin
      obstacle_on        <= 1'b1;
      obstacle_x_rom     <= w_matchDx;
      obstacle_y_rom     <= r_active[w_matchSlot].row;
      obstacle_abs_pos_x <= r_active[w_matchSlot].absX;
      obstacle_abs_pos_y <= r_active[w_matchSlot].absY;
    end else begin
      obstacle_on        <= 1'b0;
      obstacle_x_rom     <= '0;
      obstacle_y_rom     <= '0;
      obstacle_abs_pos_x <= '0;
      obstacle_abs_pos_y <= '0;
    end
  end

endmodule

// File: tb/tb_obstacle_scan_locator.sv
// Testbench for obstacle_scan_locator.
//
// A behavioural model tracks the obstacle table, the list of obstacles each
// line_start shows, scan progress and the sticky flags; a compare process
// checks every DUT output against it on each falling clock edge. Directed
// sequences add hand-computed literal expectations, then a randomized phase
// exercises writes, restarts and pixels. Honours OBSTACLE_SCAN_DROP_COUNT_EN.
`timescale 1ns/1ps
module tb_obstacle_scan_locator;

  localparam int SW    = 10;
  localparam int PW    = 14;
  localparam int OW    = 10;
  localparam int OH    = 20;
  localparam int MAXO  = 16;
  localparam int SLOTS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [3:0]    wr_idx;
  logic          wr_entry_valid;
  logic [PW-1:0] wr_abs_x;
  logic [PW-1:0] wr_abs_y;
  logic [PW-1:0] camera_y;
  logic          line_start;
  logic [SW-1:0] line_y;
  logic          pixel_valid;
  logic [SW-1:0] pixel_x;
  logic          obstacle_on;
  logic [SW-1:0] obstacle_x_rom;
  logic [SW-1:0] obstacle_y_rom;
  logic [PW-1:0] obstacle_abs_pos_x;
  logic [PW-1:0] obstacle_abs_pos_y;
  logic          slot_overflow;
  logic          scan_late;
  logic          flag_clr;
`ifdef OBSTACLE_SCAN_DROP_COUNT_EN
  logic [7:0]    drop_count;
`endif

  always #5 clk = ~clk;

  obstacle_scan_locator dut (
    .sys_clk            (clk),
    .sys_rst            (rst),
    .wr_valid           (wr_valid),
    .wr_ready           (wr_ready),
    .wr_idx             (wr_idx),
    .wr_entry_valid     (wr_entry_valid),
    .wr_abs_x           (wr_abs_x),
    .wr_abs_y           (wr_abs_y),
    .camera_y           (camera_y),
    .line_start         (line_start),
    .line_y             (line_y),
    .pixel_valid        (pixel_valid),
    .pixel_x            (pixel_x),
    .obstacle_on        (obstacle_on),
    .obstacle_x_rom     (obstacle_x_rom),
    .obstacle_y_rom     (obstacle_y_rom),
    .obstacle_abs_pos_x (obstacle_abs_pos_x),
    .obstacle_abs_pos_y (obstacle_abs_pos_y),
    .slot_overflow      (slot_overflow),
    .scan_late          (scan_late),
`ifdef OBSTACLE_SCAN_DROP_COUNT_EN
    .drop_count         (drop_count),
`endif
    .flag_clr           (flag_clr)
  );

  int testsRun    = 0;
  int testsFailed = 0;
  bit checkEn     = 1'b0;

  task automatic checkOutput(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int x;
    int y;
    int row;
  } hit_t;

  bit   mValid [MAXO];
  int   mX     [MAXO];
  int   mY     [MAXO];
  hit_t mActive[$];
  hit_t mPending[$];
  int   mDropAt[$];
  int   mScanLeft = 0;
  bit   mOverflow = 0;
  bit   mLate     = 0;
  int   mDrops    = 0;
  bit   expOn     = 0;
  int   expXr = 0, expYr = 0, expAx = 0, expAy = 0;

  task automatic modelReset();
    foreach (mValid[i]) mValid[i] = 1'b0;
    mActive.delete();
    mPending.delete();
    mDropAt.delete();
    mScanLeft = 0;
    mOverflow = 0;
    mLate     = 0;
    mDrops    = 0;
    expOn = 0; expXr = 0; expYr = 0; expAx = 0; expAy = 0;
  endtask

  // Which obstacles cross the requested line, in table order; hits past the
  // slot capacity are remembered by table index as drops.
  task automatic buildPending();
    int row;
    int diff;
    hit_t h;
    row = (int'(camera_y) + int'(line_y)) % (1 << PW);
    mPending.delete();
    mDropAt.delete();
    for (int i = 0; i < MAXO; i++) begin
      diff = (row - mY[i] + (1 << PW)) % (1 << PW);
      if (mValid[i] && diff < OH) begin
        if (mPending.size() < SLOTS) begin
          h.x = mX[i]; h.y = mY[i]; h.row = diff;
          mPending.push_back(h);
        end else begin
          mDropAt.push_back(i);
        end
      end
    end
  endtask

  task automatic computePixel();
    int px;
    int dx;
    bit found;
    px = int'(pixel_x);
    found = 0;
    expOn = 0; expXr = 0; expYr = 0; expAx = 0; expAy = 0;
    if (pixel_valid) begin
      foreach (mActive[k]) begin
        dx = (px - (mActive[k].x % (1 << SW)) + (1 << SW)) % (1 << SW);
        if (!found && dx < OW) begin
          found = 1;
          expOn = 1; expXr = dx; expYr = mActive[k].row;
          expAx = mActive[k].x; expAy = mActive[k].y;
        end
      end
    end
  endtask

  task automatic modelStep();
    bit wasScanning;
    bit ovEv;
    bit lateEv;
    int pos;
    wasScanning = (mScanLeft > 0);
    ovEv   = 0;
    lateEv = line_start && wasScanning;
    computePixel();
    if (wasScanning && !line_start) begin
      pos = MAXO - mScanLeft;
      foreach (mDropAt[k]) if (mDropAt[k] == pos) ovEv = 1;
      mScanLeft--;
    end
    if (ovEv) mOverflow = 1; else if (flag_clr) mOverflow = 0;
    if (lateEv) mLate = 1; else if (flag_clr) mLate = 0;
    if (flag_clr) mDrops = ovEv ? 1 : 0;
    else if (ovEv && mDrops < 255) mDrops++;
    if (wr_valid && !wasScanning && !line_start) begin
      mValid[int'(wr_idx)] = wr_entry_valid;
      mX[int'(wr_idx)] = int'(wr_abs_x);
      mY[int'(wr_idx)] = int'(wr_abs_y);
    end
    if (line_start) begin
      if (wasScanning) mActive.delete();
      else mActive = mPending;
      buildPending();
      mScanLeft = MAXO;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) modelReset();
    else modelStep();
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cmp_on",        int'(obstacle_on),        int'(expOn));
      checkOutput("cmp_x_rom",     int'(obstacle_x_rom),     expXr);
      checkOutput("cmp_y_rom",     int'(obstacle_y_rom),     expYr);
      checkOutput("cmp_abs_x",     int'(obstacle_abs_pos_x), expAx);
      checkOutput("cmp_abs_y",     int'(obstacle_abs_pos_y), expAy);
      checkOutput("cmp_overflow",  int'(slot_overflow),      int'(mOverflow));
      checkOutput("cmp_scan_late", int'(scan_late),          int'(mLate));
      checkOutput("cmp_wr_ready",  int'(wr_ready),
                  int'((mScanLeft == 0) && !line_start));
`ifdef OBSTACLE_SCAN_DROP_COUNT_EN
      checkOutput("cmp_drop_count", int'(drop_count), mDrops);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeEntry(input int idx, input bit en, input int x, input int y);
    wr_valid       = 1'b1;
    wr_idx         = 4'(idx);
    wr_entry_valid = en;
    wr_abs_x       = PW'(x);
    wr_abs_y       = PW'(y);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulseLine(input int ly, input int cam);
    line_start = 1'b1;
    line_y     = SW'(ly);
    camera_y   = PW'(cam);
    tick();
    line_start = 1'b0;
  endtask

  task automatic waitScan();
    repeat (MAXO) tick();
  endtask

  task automatic applyPixel(input int px);
    pixel_valid = 1'b1;
    pixel_x     = SW'(px);
    tick();
    pixel_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int lines);
    int len;
    for (int ln = 0; ln < lines; ln++) begin
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 14) : $urandom_range(17, 50);
      camera_y = PW'($urandom_range(0, 63));
      line_y   = SW'($urandom_range(0, 63));
      for (int c = 0; c < len; c++) begin
        line_start     = (c == 0);
        wr_valid       = ($urandom_range(0, 2) == 0);
        wr_idx         = 4'($urandom_range(0, 15));
        wr_entry_valid = ($urandom_range(0, 7) != 0);
        wr_abs_x       = PW'($urandom_range(0, 300) + (($urandom_range(0, 3) == 0) ? 4096 : 0));
        wr_abs_y       = PW'($urandom_range(0, 140));
        pixel_valid    = ($urandom_range(0, 3) != 0);
        pixel_x        = SW'($urandom_range(0, 320));
        flag_clr       = ($urandom_range(0, 19) == 0);
        tick();
      end
    end
    line_start = 1'b0; wr_valid = 1'b0; pixel_valid = 1'b0; flag_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  int cnt;

  initial begin
    rst = 1'b1;
    wr_valid = 0; wr_idx = 0; wr_entry_valid = 0; wr_abs_x = 0; wr_abs_y = 0;
    camera_y = 0; line_start = 0; line_y = 0; pixel_valid = 0; pixel_x = 0; flag_clr = 0;
    #2 checkEn = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_wr_ready", int'(wr_ready), 1);
    checkOutput("reset_on", int'(obstacle_on), 0);
    checkOutput("reset_overflow", int'(slot_overflow), 0);
    checkOutput("reset_scan_late", int'(scan_late), 0);

    // single obstacle, hit and near misses
    writeEntry(3, 1, 100, 50);
    pulseLine(55, 0);
    waitScan();
    pulseLine(55, 0);
    applyPixel(105);
    checkOutput("t1_on", int'(obstacle_on), 1);
    checkOutput("t1_x_rom", int'(obstacle_x_rom), 5);
    checkOutput("t1_y_rom", int'(obstacle_y_rom), 5);
    checkOutput("t1_abs_x", int'(obstacle_abs_pos_x), 100);
    checkOutput("t1_abs_y", int'(obstacle_abs_pos_y), 50);
    checkOutput("t1_model_x_rom", expXr, 5);
    checkOutput("t1_model_y_rom", expYr, 5);
    applyPixel(110);
    checkOutput("t2_on_110", int'(obstacle_on), 0);
    checkOutput("t2_abs_x_110", int'(obstacle_abs_pos_x), 0);
    applyPixel(99);
    checkOutput("t2_on_99", int'(obstacle_on), 0);
    checkOutput("t2_x_rom_99", int'(obstacle_x_rom), 0);
    waitScan();

    // six hits on one line: four shown, two dropped
    for (int k = 0; k < 6; k++) writeEntry(k, 1, 20 + 100 * k, 200 - k);
    pulseLine(200, 0);
    waitScan();
    checkOutput("t3_overflow", int'(slot_overflow), 1);
`ifdef OBSTACLE_SCAN_DROP_COUNT_EN
    checkOutput("t3_drop_count", int'(drop_count), 2);
`endif
    pulseLine(200, 0);
    applyPixel(320);
    checkOutput("t3_on_slot3", int'(obstacle_on), 1);
    checkOutput("t3_y_rom_slot3", int'(obstacle_y_rom), 3);
    checkOutput("t3_abs_x_slot3", int'(obstacle_abs_pos_x), 320);
    applyPixel(420);
    checkOutput("t3_on_dropped", int'(obstacle_on), 0);
    waitScan();
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    checkOutput("t3_overflow_clr", int'(slot_overflow), 0);
`ifdef OBSTACLE_SCAN_DROP_COUNT_EN
    checkOutput("t3_drop_count_clr", int'(drop_count), 0);
`endif

    // overlapping obstacles: lowest slot wins
    writeEntry(0, 1, 100, 200);
    writeEntry(1, 1, 104, 198);
    for (int k = 2; k < 6; k++) writeEntry(k, 0, 0, 0);
    pulseLine(200, 0);
    waitScan();
    pulseLine(200, 0);
    applyPixel(106);
    checkOutput("t4_on", int'(obstacle_on), 1);
    checkOutput("t4_x_rom", int'(obstacle_x_rom), 6);
    checkOutput("t4_abs_x", int'(obstacle_abs_pos_x), 100);
    waitScan();

    // restart mid-scan
    pulseLine(200, 0);
    repeat (4) tick();
    pulseLine(200, 0);
    checkOutput("t5_scan_late", int'(scan_late), 1);
    checkOutput("t5_wr_ready_low", int'(wr_ready), 0);
    cnt = 0;
    while (!wr_ready && cnt < 40) begin
      tick();
      cnt++;
    end
    checkOutput("t5_scan_cycles", cnt, 16);
    applyPixel(106);
    checkOutput("t5_empty_line", int'(obstacle_on), 0);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    checkOutput("t5_late_clr", int'(scan_late), 0);

    // world row wrap, then reset mid-scan
    writeEntry(7, 1, 50, 16380);
    pulseLine(10, 16375);
    waitScan();
    pulseLine(10, 16375);
    pixel_valid = 1'b1;
    pixel_x     = 10'd52;
    tick();
    checkOutput("t6_on", int'(obstacle_on), 1);
    checkOutput("t6_x_rom", int'(obstacle_x_rom), 2);
    checkOutput("t6_y_rom", int'(obstacle_y_rom), 5);
    checkOutput("t6_abs_y", int'(obstacle_abs_pos_y), 16380);
    #3 rst = 1'b1;
    #1;
    checkOutput("t6_rst_on", int'(obstacle_on), 0);
    checkOutput("t6_rst_abs_y", int'(obstacle_abs_pos_y), 0);
    checkOutput("t6_rst_wr_ready", int'(wr_ready), 1);
    pixel_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    pulseLine(10, 16375);
    waitScan();
    pulseLine(10, 16375);
    applyPixel(52);
    checkOutput("t6_table_cleared", int'(obstacle_on), 0);
    waitScan();

    applyStimulus(60);
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
